seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed driver for a common-anode 7-segment display bank: one segment bus shared across NUM_DIGITS digits.
- Latches a hex word, scans digits round-robin at a prescaled rate, encodes each nibble to an active-low segment pattern, and drives one active-low anode at a time.
- Inserts a blanking gap between digit slots to suppress ghosting.
- Sits between the CPU debug/IO register (PC, register or bus value) and the board display pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; the data word is 4*NUM_DIGITS bits.
- CLK_DIV, 50000, clock cycles per digit slot; must be at least 2.
- BLANK_CYC, 500, cycles at the start of each slot with all anodes off; must be less than CLK_DIV.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  scan enable; 0 turns the display dark and holds the scan at digit 0.
- load  in  1  single-cycle strobe; captures data_in, dp_mask and blank_mask.
- data_in  in  4*NUM_DIGITS  hex word; nibble k goes to digit k; digit 0 is rightmost.
- dp_mask  in  NUM_DIGITS  1 lights the decimal point of digit k.
- blank_mask  in  NUM_DIGITS  1 keeps digit k dark.
- an  out  NUM_DIGITS  anode selects, active-low, at most one low.
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (async, rst=1):
  - an all ones; seg=8'hFF.
  - Shadow data, dp and blank registers cleared to 0.
  - Slot counter cnt=0; digit index idx=0; state IDLE.
- Shadow registers:
  - load=1 at an edge captures all three inputs.
  - Without load, the shadow registers hold.
  - Load is accepted in any state, including when enable=0.
- Scan state machine:
  - IDLE: enable=0. cnt and idx held at 0. On enable=1 go to BLANK.
  - BLANK: applies while cnt<BLANK_CYC. If BLANK_CYC=0, BLANK is skipped and entry goes straight to DRIVE.
  - DRIVE: applies while BLANK_CYC<=cnt<=CLK_DIV-1.
- Counters:
  - cnt increments by 1 each cycle while enabled.
  - At cnt=CLK_DIV-1: cnt becomes 0 and idx advances by 1, wrapping NUM_DIGITS-1 to 0. The next state is BLANK.
- enable deasserted in any state: next edge returns to IDLE, cnt=0, idx=0. Re-enabling always restarts at digit 0, slot start.
- Outputs are registered, computed from the current state, cnt, idx and shadow values:
  - IDLE or BLANK: an all ones, seg=8'hFF.
  - DRIVE with blank_mask[idx]=1: an all ones, seg=8'hFF. The slot still consumes its full time so brightness stays uniform.
  - DRIVE otherwise: an has bit idx low and all other bits high; seg[6:0]=HEX_SEG[nibble idx]; seg[7]=~dp[idx].
- Latency:
  - Outputs lag the state/counter values by exactly one cycle.
  - A load at edge t is first visible on seg at edge t+1, provided the digit is being driven.
- Simultaneous load and slot rollover: the new digit's slot uses the newly loaded data.
- Segment code, as {g..a} active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset mid-slot: outputs go dark immediately (async); scanning resumes at digit 0 after release.

Decomposition:
- Package seg_pkg holds:
  - HEX_SEG[16] 7-bit active-low constant table.
  - SEG_OFF=8'hFF.
  - State enum {IDLE, BLANK, DRIVE}.
- One natural sub-module: seg_prescaler. It contains the slot counter and digit index and produces slot_end, in_blank and idx.
- The shadow registers, output mux and encoding stay in seg_scan_ctrl.

Test Plan:
All scenarios use NUM_DIGITS=4, CLK_DIV=4, BLANK_CYC=1.
- Reset then enable=1 with no load -> digit 0 driven: an=4'b1110, seg=8'b11000000 for 3 cycles, preceded by 1 dark cycle; then digit 1 an=4'b1101 with the same pattern.
- load data_in=16'h1234, dp_mask=4'b0010 -> per slot:
  - digit 0: seg=8'b10011001
  - digit 1: seg=8'b00110000 (dp lit)
  - digit 2: seg=8'b10100100
  - digit 3: seg=8'b11111001
  - then wraps to digit 0.
- blank_mask=4'b1000 with data 16'hF00A -> the digit 3 slot stays dark (an=4'b1111) for all 4 cycles; digit 0 shows seg=8'b10001000.
- Drop enable mid-DRIVE on digit 2 -> next cycle an=4'b1111, seg=8'hFF; re-enable -> 1 dark cycle, then digit 0.
- load pulse coinciding with slot rollover, changing nibble 1 from 3 to E -> the digit 1 slot shows seg=8'b10000110.
- Assert rst asynchronously mid-cycle -> an=4'b1111 and seg=8'hFF without waiting for a clock edge; shadow cleared, so digit 0 shows "0" after release.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_pkg;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // All segments and the decimal point off.
    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    // Full active-low segment byte {dp,g..a} for one nibble.
    function automatic logic [7:0] seg_encode(input logic [3:0] nib, input logic dp);
        return {~dp, HEX_SEG[nib]};
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_prescaler.sv
// Slot timing for the scan: slot counter, digit index and the IDLE/BLANK/DRIVE sequencer.
module seg_prescaler
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 50000,
    parameter int BLANK_CYC  = 500,
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    output logic             o_slot_end,
    output logic             o_in_blank,
    output logic [IDX_W-1:0] o_idx
);

    localparam int CNT_W = $clog2(CLK_DIV);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;

    logic             w_slot_end;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    state_t           w_state_nxt;

    // Next counter/index values; the state follows from where the next count falls in the slot.
    always_comb begin
        w_slot_end = (r_state != IDLE) && (r_cnt == CNT_W'(CLK_DIV - 1));
        w_idx_nxt  = r_idx;
        if (r_state == IDLE || w_slot_end) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
        if (w_slot_end) begin
            w_idx_nxt = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end
        // With BLANK_CYC=0 this never selects BLANK, so slots start directly in DRIVE.
        w_state_nxt = (int'(w_cnt_nxt) < BLANK_CYC) ? BLANK : DRIVE;
    end

    // Scan sequencer; dropping enable parks everything at digit 0, slot start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else if (!i_enable) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    assign o_slot_end = w_slot_end;
    assign o_in_blank = (r_state != DRIVE);
    assign o_idx      = r_idx;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment driver: shadow registers, digit mux and encoding.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 50000,
    parameter int BLANK_CYC  = 500
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_data_in,
    input  logic [NUM_DIGITS-1:0]   i_dp_mask,
    input  logic [NUM_DIGITS-1:0]   i_blank_mask,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic [7:0]              o_seg
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] r_data;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [7:0]              r_seg;

    logic                    w_slot_end;
    logic                    w_in_blank;
    logic [IDX_W-1:0]        w_idx;

    seg_prescaler #(
        .NUM_DIGITS (NUM_DIGITS),
        .CLK_DIV    (CLK_DIV),
        .BLANK_CYC  (BLANK_CYC)
    ) u_prescaler (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_enable   (i_enable),
        .o_slot_end (w_slot_end),
        .o_in_blank (w_in_blank),
        .o_idx      (w_idx)
    );

    // Shadow copy of the display word; a load is accepted whatever the scan is doing.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data  <= '0;
            r_dp    <= '0;
            r_blank <= '0;
        end else if (i_load) begin
            r_data  <= i_data_in;
            r_dp    <= i_dp_mask;
            r_blank <= i_blank_mask;
        end
    end

    // Registered pin drive from the current slot; masked digits stay dark but keep their slot time.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_an  <= '1;
            r_seg <= SEG_OFF;
        end else if (w_in_blank || r_blank[w_idx]) begin
            r_an  <= '1;
            r_seg <= SEG_OFF;
        end else begin
            r_an  <= ~(NUM_DIGITS'(1) << w_idx);
            r_seg <= seg_encode(r_data[w_idx*4 +: 4], r_dp[w_idx]);
        end
    end

    assign o_an  = r_an;
    assign o_seg = r_seg;

endmodule
